maxpool_2x2_engine: RTL and testbench

Layer-side responder for the CNN accelerator's start/done layer handshake. It accepts a one-cycle `start` from the layer sequencer and performs 2x2, stride-2 signed max pooling over a square feature map held stable on its input bus. It scans one element per cycle, writes pooled results into a registered output map, and raises a sticky `done`. It sits between the convolution engine's output map and the fully connected layer's input.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/pool_addr_gen.sv | 36 +++
 rtl/maxpool_2x2_engine.sv | 144 ++++++++++++++
 tb/tb_maxpool_2x2_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared by the CNN accelerator layer responders.
//   CNN_DW     - element width (signed two's complement)
//   CONV_DIM   - side of the convolution engine output map (pool input)
//   POOL_DIM   - side of the pooled map handed to the fully connected layer
//   layer_state_e - IDLE/SCAN/DONE encoding for start/done layer handshakes
//   clog2_min1 - $clog2 that never returns 0, for counter/index widths
package cnn_pkg;

    localparam int CNN_DW   = 32;
    localparam int CONV_DIM = 6;
    localparam int POOL_DIM = CONV_DIM / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } layer_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: combinational window address generator for stride-WIN pooling.
// Maps window (wr, wc) and in-window offset (kr, kc) to the flat row-major
// input element index and the flat output element index.
//   wr, wc   in  window row / column
//   kr, kc   in  row / column offset inside the window
//   in_idx   out input element index  (WIN*wr+kr)*IN_DIM + WIN*wc+kc
//   out_idx  out output element index wr*OUT_DIM + wc
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IN_DIM  = CONV_DIM,
    parameter int WIN     = 2,
    parameter int OUT_DIM = IN_DIM / WIN,
    parameter int CW      = clog2_min1(OUT_DIM),
    parameter int KW      = clog2_min1(WIN),
    parameter int IW      = clog2_min1(IN_DIM * IN_DIM),
    parameter int OW      = clog2_min1(OUT_DIM * OUT_DIM)
) (
    input  logic [CW-1:0] wr,
    input  logic [CW-1:0] wc,
    input  logic [KW-1:0] kr,
    input  logic [KW-1:0] kc,
    output logic [IW-1:0] in_idx,
    output logic [OW-1:0] out_idx
);

    int row, col;

    always_comb begin
        row     = WIN * int'(wr) + int'(kr);
        col     = WIN * int'(wc) + int'(kc);
        in_idx  = IW'(row * IN_DIM + col);
        out_idx = OW'(int'(wr) * OUT_DIM + int'(wc));
    end

endmodule

// File: rtl/maxpool_2x2_engine.sv
// maxpool_2x2_engine: 2x2 stride-2 signed max pooling responder for the layer
// start/done handshake. Scans one input element per cycle in window order and
// writes each pooled result into a registered output map.
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle request; accepted in IDLE or DONE, ignored in SCAN
//   input_fm   flattened row-major input map, held stable while busy
//   output_fm  flattened row-major pooled map (registered)
//   busy       high while scanning
//   done       sticky completion, cleared by the next accepted start or rst
// Build option: MAXPOOL_RELU_FUSE_EN clamps negative written results to 0.
module maxpool_2x2_engine
    import cnn_pkg::*;
#(
    parameter int DW     = CNN_DW,
    parameter int IN_DIM = CONV_DIM
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [IN_DIM*IN_DIM*DW-1:0]        input_fm,
    output logic [(IN_DIM/2)*(IN_DIM/2)*DW-1:0] output_fm,
    output logic                               busy,
    output logic                               done
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int NOUT    = OUT_DIM * OUT_DIM;
    localparam int CW      = clog2_min1(OUT_DIM);
    localparam int IW      = clog2_min1(IN_DIM * IN_DIM);
    localparam int OW      = clog2_min1(NOUT);

    layer_state_e  state_q, state_d;
    logic [CW-1:0] wr_q, wr_d, wc_q, wc_d;
    logic [1:0]    k_q, k_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] out_q [NOUT];

    logic [IW-1:0] in_idx;
    logic [OW-1:0] out_idx;
    logic [DW-1:0] elem, cmp_max, wval;
    logic          wr_en;

    pool_addr_gen #(
        .IN_DIM (IN_DIM),
        .WIN    (2),
        .OUT_DIM(OUT_DIM),
        .CW     (CW),
        .KW     (1),
        .IW     (IW),
        .OW     (OW)
    ) u_addr (
        .wr     (wr_q),
        .wc     (wc_q),
        .kr     (k_q[1]),
        .kc     (k_q[0]),
        .in_idx (in_idx),
        .out_idx(out_idx)
    );

    assign elem    = input_fm[in_idx*DW +: DW];
    assign cmp_max = ($signed(elem) > $signed(max_q)) ? elem : max_q;

`ifdef MAXPOOL_RELU_FUSE_EN
    assign wval = cmp_max[DW-1] ? '0 : cmp_max;
`else
    assign wval = cmp_max;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        k_d     = k_q;
        max_d   = max_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    wr_d    = '0;
                    wc_d    = '0;
                    k_d     = '0;
                end
            end
            ST_SCAN: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd0) begin
                    max_d = elem;
                end else if (k_q != 2'd3) begin
                    max_d = cmp_max;
                end else begin
                    // last element of the window: commit and step to next window
                    wr_en = 1'b1;
                    if (wc_q == CW'(OUT_DIM - 1)) begin
                        wc_d = '0;
                        if (wr_q == CW'(OUT_DIM - 1)) begin
                            wr_d    = '0;
                            state_d = ST_DONE;
                        end else begin
                            wr_d = wr_q + 1'b1;
                        end
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            wc_q    <= '0;
            k_q     <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            k_q     <= k_d;
            max_q   <= max_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < NOUT; g++) begin
            if (rst) begin
                out_q[g] <= '0;
            end else if (wr_en && out_idx == OW'(g)) begin
                out_q[g] <= wval;
            end
        end
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_out
        assign output_fm[g*DW +: DW] = out_q[g];
    end

    assign busy = (state_q == ST_SCAN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_maxpool_2x2_engine.sv
module tb_maxpool_2x2_engine;

    localparam int DW = 32;
    localparam int N  = 6;
    localparam int M  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [N*N*DW-1:0]  input_fm;
    logic [M*M*DW-1:0]  output_fm;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_ramp [M*M] = '{32'd7, 32'd9, 32'd11, 32'd19, 32'd21, 32'd23, 32'd31, 32'd33, 32'd35};
    logic [DW-1:0] exp_rev  [M*M] = '{32'd35, 32'd33, 32'd31, 32'd23, 32'd21, 32'd19, 32'd11, 32'd9, 32'd7};

    maxpool_2x2_engine #(.DW(DW), .IN_DIM(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .input_fm (input_fm),
        .output_fm(output_fm),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic load_ramp();
        for (int i = 0; i < N*N; i++) input_fm[i*DW +: DW] = DW'(i);
    endtask

    task automatic load_rev();
        for (int i = 0; i < N*N; i++) input_fm[i*DW +: DW] = DW'(N*N - 1 - i);
    endtask

    // Pulse start (sampled at E0) and wait for done; lat = edges after E0.
    // A second start is offered at edge E(repulse_at) when repulse_at > 0.
    task automatic run_pool(input int repulse_at, output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            start = (repulse_at > 0 && lat == repulse_at - 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; input_fm = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== '0) begin
                failures++;
                $display("FAIL reset_out[%0d] got=%h want=0", j, output_fm[j*DW +: DW]);
            end
        end
    endtask

    task automatic test_ramp();
        int busy_cnt = 0;
        int lat = 0;
        load_ramp();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ramp_after_E0 busy=%b done=%b want 1 0", busy, done);
        end
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL ramp_busy_done_overlap at cycle %0d", lat);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL ramp_latency got=%0d want=36", lat);
        end
        checks++;
        if (busy_cnt !== 36 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ramp_busy_cycles got=%0d busy_end=%b want 36 0", busy_cnt, busy);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== exp_ramp[j]) begin
                failures++;
                $display("FAIL ramp_out[%0d] got=%0d want=%0d", j, output_fm[j*DW +: DW], exp_ramp[j]);
            end
        end
    endtask

    task automatic test_negative();
        int lat;
        logic [DW-1:0] want;
`ifdef MAXPOOL_RELU_FUSE_EN
        want = '0;
`else
        want = -32'sd2;
`endif
        for (int i = 0; i < N*N; i++) input_fm[i*DW +: DW] = -32'sd5;
        // one -2 per window, at a varying in-window position
        for (int w = 0; w < M*M; w++) begin
            int r, c, k;
            k = w % 4;
            r = 2*(w / M) + k / 2;
            c = 2*(w % M) + k % 2;
            input_fm[(r*N + c)*DW +: DW] = -32'sd2;
        end
        run_pool(0, lat);
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL neg_latency got=%0d want=36", lat);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== want) begin
                failures++;
                $display("FAIL neg_out[%0d] got=%h want=%h", j, output_fm[j*DW +: DW], want);
            end
        end
    endtask

    task automatic test_signed_extremes();
        int lat;
        logic [DW-1:0] want1;
`ifdef MAXPOOL_RELU_FUSE_EN
        want1 = '0;
`else
        want1 = 32'h8000_0000;
`endif
        input_fm = '0;
        input_fm[0*DW +: DW] = 32'h8000_0000;
        input_fm[1*DW +: DW] = 32'hFFFF_FFFF;
        input_fm[6*DW +: DW] = 32'h0000_0000;
        input_fm[7*DW +: DW] = 32'h7FFF_FFFF;
        input_fm[2*DW +: DW] = 32'h8000_0000;
        input_fm[3*DW +: DW] = 32'h8000_0000;
        input_fm[8*DW +: DW] = 32'h8000_0000;
        input_fm[9*DW +: DW] = 32'h8000_0000;
        run_pool(0, lat);
        checks++;
        if (output_fm[0*DW +: DW] !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL signed_mix got=%h want=7fffffff", output_fm[0*DW +: DW]);
        end
        checks++;
        if (output_fm[1*DW +: DW] !== want1) begin
            failures++;
            $display("FAIL all_min got=%h want=%h", output_fm[1*DW +: DW], want1);
        end
        checks++;
        if (output_fm[2*DW +: DW] !== 32'd0) begin
            failures++;
            $display("FAIL zero_window got=%h want=0", output_fm[2*DW +: DW]);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        input_fm = '0;
        run_pool(0, lat);
        load_ramp();
        run_pool(10, lat);
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL restart_ignored_latency got=%0d want=36", lat);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== exp_ramp[j]) begin
                failures++;
                $display("FAIL restart_out[%0d] got=%0d want=%0d", j, output_fm[j*DW +: DW], exp_ramp[j]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        load_ramp();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (output_fm !== '0) begin
            failures++;
            $display("FAIL midrst_out got=%h want=0", output_fm);
        end
        run_pool(0, lat);
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL midrst_rerun_latency got=%0d want=36", lat);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== exp_ramp[j]) begin
                failures++;
                $display("FAIL midrst_out[%0d] got=%0d want=%0d", j, output_fm[j*DW +: DW], exp_ramp[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        load_ramp();
        run_pool(0, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL done_sticky cycle=%0d done=%b busy=%b want 1 0", c, done, busy);
            end
        end
        load_rev();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_from_done done=%b busy=%b want 0 1", done, busy);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL rev_latency got=%0d want=36", lat);
        end
        for (int j = 0; j < M*M; j++) begin
            checks++;
            if (output_fm[j*DW +: DW] !== exp_rev[j]) begin
                failures++;
                $display("FAIL rev_out[%0d] got=%0d want=%0d", j, output_fm[j*DW +: DW], exp_rev[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_signed_extremes();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
